// File: rtl/csr_mreg.sv
// Machine-mode CSR file: trap/mret status updates, instruction CSR access,
// 64-bit cycle/instret counters and feedback to the exception unit.
module csr_mreg #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] MTVEC_RST = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [11:0]     csr_rd_addr_i,
  output logic [XLEN-1:0] csr_rd_data_o,
  output logic            csr_illegal_o,
  input  logic            csr_wen_i,
  input  logic [11:0]     csr_wr_addr_i,
  input  logic [XLEN-1:0] csr_wr_data_i,
  input  logic            csr_mcause_wen_i,
  input  logic [XLEN-1:0] csr_mcause_i,
  input  logic            csr_mepc_wen_i,
  input  logic [XLEN-1:0] csr_mepc_i,
  input  logic            csr_mtval_wen_i,
  input  logic [XLEN-1:0] csr_mtval_i,
  input  logic            csr_mstatus_wen_i,
  input  logic            mret_i,
  input  logic            instret_i,
  input  logic            int_soft_i,
  input  logic            int_timer_i,
  input  logic            int_exter_i,
  output logic            u_mode_o,
  output logic            s_mode_o,
  output logic            h_mode_o,
  output logic            m_mode_o,
  output logic            csr_mstatus_mie_o,
  output logic            csr_msie_o,
  output logic            csr_mtie_o,
  output logic            csr_meie_o,
  output logic [XLEN-1:0] csr_mtvec_o,
  output logic [XLEN-1:0] csr_mepc_o
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MINSTRET = 12'hB02;
  localparam logic [11:0] A_MCYCLEH  = 12'hB80;
  localparam logic [11:0] A_MINSTRTH = 12'hB82;
  localparam logic [11:0] A_MHARTID  = 12'hF14;

  // priv_q: 1 = M, 0 = U
  logic            priv_q, priv_d;
  logic            mie_q, mie_d;
  logic            mpie_q, mpie_d;
  logic [1:0]      mpp_q, mpp_d;
  logic            msie_q, msie_d;
  logic            mtie_q, mtie_d;
  logic            meie_q, meie_d;
  logic            msip_q, mtip_q, meip_q;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic [XLEN-1:0] cyc_lo_q, cyc_lo_d;
  logic [XLEN-1:0] cyc_hi_q, cyc_hi_d;
  logic [XLEN-1:0] ins_lo_q, ins_lo_d;
  logic [XLEN-1:0] ins_hi_q, ins_hi_d;

  logic [XLEN-1:0] mstatus_rd, mie_rd, mip_rd;
  logic            trap_any, mret_eff;
  logic [XLEN:0]   cyc_lo_inc, ins_lo_inc;

  function automatic logic impl(input logic [11:0] a);
    unique case (a)
      A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH,
      A_MEPC, A_MCAUSE, A_MTVAL, A_MIP,
      A_MCYCLE, A_MINSTRET, A_MCYCLEH,
      A_MINSTRTH, A_MHARTID: impl = 1'b1;
      default:               impl = 1'b0;
    endcase
  endfunction

  function automatic logic wr_hit(input logic [11:0] a);
    wr_hit = csr_wen_i && (csr_wr_addr_i == a);
  endfunction

  assign mstatus_rd = {19'b0, mpp_q, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
  assign mie_rd     = {20'b0, meie_q, 3'b0, mtie_q, 3'b0, msie_q, 3'b0};
  assign mip_rd     = {20'b0, meip_q, 3'b0, mtip_q, 3'b0, msip_q, 3'b0};

  always_comb begin
    csr_rd_data_o = '0;
    unique case (csr_rd_addr_i)
      A_MSTATUS:  csr_rd_data_o = mstatus_rd;
      A_MIE:      csr_rd_data_o = mie_rd;
      A_MTVEC:    csr_rd_data_o = mtvec_q;
      A_MSCRATCH: csr_rd_data_o = mscratch_q;
      A_MEPC:     csr_rd_data_o = mepc_q;
      A_MCAUSE:   csr_rd_data_o = mcause_q;
      A_MTVAL:    csr_rd_data_o = mtval_q;
      A_MIP:      csr_rd_data_o = mip_rd;
      A_MCYCLE:   csr_rd_data_o = cyc_lo_q;
      A_MCYCLEH:  csr_rd_data_o = cyc_hi_q;
      A_MINSTRET: csr_rd_data_o = ins_lo_q;
      A_MINSTRTH: csr_rd_data_o = ins_hi_q;
      default:    csr_rd_data_o = '0;
    endcase
  end

  assign csr_illegal_o = !impl(csr_rd_addr_i)
                       || (csr_wen_i && !impl(csr_wr_addr_i));

  assign trap_any = csr_mstatus_wen_i | csr_mcause_wen_i
                  | csr_mepc_wen_i | csr_mtval_wen_i;
  assign mret_eff = mret_i & ~trap_any;

  // Status/privilege: trap entry, then mret, then instruction write
  always_comb begin
    priv_d = priv_q;
    mie_d  = mie_q;
    mpie_d = mpie_q;
    mpp_d  = mpp_q;
    if (csr_mstatus_wen_i) begin
      mpie_d = mie_q;
      mie_d  = 1'b0;
      mpp_d  = priv_q ? 2'b11 : 2'b00;
      priv_d = 1'b1;
    end else if (mret_eff) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
      priv_d = (mpp_q == 2'b11);
      mpp_d  = 2'b00;
    end else if (wr_hit(A_MSTATUS)) begin
      mie_d  = csr_wr_data_i[3];
      mpie_d = csr_wr_data_i[7];
      mpp_d  = (csr_wr_data_i[12:11] == 2'b11) ? 2'b11 : 2'b00;
    end
  end

  always_comb begin
    msie_d     = msie_q;
    mtie_d     = mtie_q;
    meie_d     = meie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    if (wr_hit(A_MIE)) begin
      msie_d = csr_wr_data_i[3];
      mtie_d = csr_wr_data_i[7];
      meie_d = csr_wr_data_i[11];
    end
    if (wr_hit(A_MTVEC))
      mtvec_d = {csr_wr_data_i[XLEN-1:2], 2'b00};
    if (wr_hit(A_MSCRATCH))
      mscratch_d = csr_wr_data_i;
    if (csr_mepc_wen_i)
      mepc_d = {csr_mepc_i[XLEN-1:2], 2'b00};
    else if (wr_hit(A_MEPC))
      mepc_d = {csr_wr_data_i[XLEN-1:2], 2'b00};
    if (csr_mcause_wen_i)
      mcause_d = csr_mcause_i;
    else if (wr_hit(A_MCAUSE))
      mcause_d = csr_wr_data_i;
    if (csr_mtval_wen_i)
      mtval_d = csr_mtval_i;
    else if (wr_hit(A_MTVAL))
      mtval_d = csr_wr_data_i;
  end

  // A written low half neither increments nor carries
  assign cyc_lo_inc = {1'b0, cyc_lo_q} + {{XLEN{1'b0}}, 1'b1};
  assign ins_lo_inc = {1'b0, ins_lo_q} + {{XLEN{1'b0}}, instret_i};

  always_comb begin
    cyc_lo_d = cyc_lo_inc[XLEN-1:0];
    cyc_hi_d = cyc_hi_q + {{(XLEN-1){1'b0}}, cyc_lo_inc[XLEN]};
    ins_lo_d = ins_lo_inc[XLEN-1:0];
    ins_hi_d = ins_hi_q + {{(XLEN-1){1'b0}}, ins_lo_inc[XLEN]};
    if (wr_hit(A_MCYCLE)) begin
      cyc_lo_d = csr_wr_data_i;
      cyc_hi_d = cyc_hi_q;
    end
    if (wr_hit(A_MCYCLEH))
      cyc_hi_d = csr_wr_data_i;
    if (wr_hit(A_MINSTRET)) begin
      ins_lo_d = csr_wr_data_i;
      ins_hi_d = ins_hi_q;
    end
    if (wr_hit(A_MINSTRTH))
      ins_hi_d = csr_wr_data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      priv_q     <= 1'b1;
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mpp_q      <= 2'b00;
      msie_q     <= 1'b0;
      mtie_q     <= 1'b0;
      meie_q     <= 1'b0;
      msip_q     <= 1'b0;
      mtip_q     <= 1'b0;
      meip_q     <= 1'b0;
      mtvec_q    <= MTVEC_RST;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      cyc_lo_q   <= '0;
      cyc_hi_q   <= '0;
      ins_lo_q   <= '0;
      ins_hi_q   <= '0;
    end else begin
      priv_q     <= priv_d;
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mpp_q      <= mpp_d;
      msie_q     <= msie_d;
      mtie_q     <= mtie_d;
      meie_q     <= meie_d;
      msip_q     <= int_soft_i;
      mtip_q     <= int_timer_i;
      meip_q     <= int_exter_i;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      cyc_lo_q   <= cyc_lo_d;
      cyc_hi_q   <= cyc_hi_d;
      ins_lo_q   <= ins_lo_d;
      ins_hi_q   <= ins_hi_d;
    end
  end

  assign u_mode_o          = ~priv_q;
  assign s_mode_o          = 1'b0;
  assign h_mode_o          = 1'b0;
  assign m_mode_o          = priv_q;
  assign csr_mstatus_mie_o = mie_q;
  assign csr_msie_o        = msie_q;
  assign csr_mtie_o        = mtie_q;
  assign csr_meie_o        = meie_q;
  assign csr_mtvec_o       = mtvec_q;
  assign csr_mepc_o        = mepc_q;

endmodule
